// File: rtl/heartbeat_generator.sv
// heartbeat_generator: transmit end of the watchdog link.
// Emits periodic heartbeat pulses while every unmasked liveness source is fresh; withholds
// beats when a source stalls and latches HALT after MISS_LIMIT consecutive missed ticks.
// Also turns a rising edge on kick_req into a one-cycle force_reset pulse.
// Optional feature macro: HB_STATS_EN enables the beat_count / miss_total counters;
// without it both ports read 16'h0.
module heartbeat_generator #(
  parameter int unsigned PERIOD      = 1000,
  parameter int unsigned PULSE_W     = 1,
  parameter int unsigned N_SRC       = 3,
  parameter int unsigned SRC_TIMEOUT = 4000,
  parameter int unsigned MISS_LIMIT  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [N_SRC-1:0] src_alive,
  input  logic [N_SRC-1:0] src_mask,
  input  logic             kick_req,
  output logic             heartbeat,
  output logic             force_reset,
  output logic [N_SRC-1:0] stale,
  output logic             halted,
  output logic [15:0]      beat_count,
  output logic [15:0]      miss_total
);

  localparam int unsigned PcW = $clog2(PERIOD);
  localparam int unsigned PwW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
  localparam int unsigned ScW = $clog2(SRC_TIMEOUT + 1);
  localparam int unsigned McW = $clog2(MISS_LIMIT + 1);

  localparam logic [PcW-1:0] PeriodLast = PcW'(PERIOD - 1);
  localparam logic [PwW-1:0] PulseLast  = PwW'(PULSE_W - 1);
  localparam logic [ScW-1:0] Timeout    = ScW'(SRC_TIMEOUT);
  localparam logic [McW-1:0] MissLimit  = McW'(MISS_LIMIT);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPulse,
    StHalt
  } state_e;

  state_e             state_q, state_d;
  logic [PcW-1:0]     period_q, period_d;
  logic [PwW-1:0]     pulse_q, pulse_d;
  logic [McW-1:0]     miss_q, miss_d;
  logic [McW-1:0]     miss_plus;
  logic [ScW-1:0]     stale_cnt_q [N_SRC];
  logic [ScW-1:0]     stale_cnt_d [N_SRC];
  logic [N_SRC-1:0]   stale_q, stale_d;
  logic               heartbeat_q, heartbeat_d;
  logic               force_q, force_d;
  logic               halted_q, halted_d;
  logic               kick_prev_q;
  logic               tick;
  logic               health_ok;

  // A tick is the last count of the period while waiting in RUN.
  assign tick      = (state_q == StRun) && (period_q == PeriodLast);
  // A same-cycle alive strobe rescues a source that is currently flagged stale.
  assign health_ok = &(src_mask | src_alive | ~stale_q);
  assign miss_plus = miss_q + McW'(1);

  // Per-source inactivity counters, saturating at the timeout.
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      stale_cnt_d[i] = stale_cnt_q[i];
      if (!enable || src_alive[i]) begin
        stale_cnt_d[i] = '0;
      end else if (stale_cnt_q[i] != Timeout) begin
        stale_cnt_d[i] = stale_cnt_q[i] + ScW'(1);
      end
      stale_d[i] = (stale_cnt_d[i] == Timeout);
    end
  end

  // Beat FSM next state, period/pulse/miss counters and registered output values.
  always_comb begin
    state_d  = state_q;
    period_d = (period_q == PeriodLast) ? '0 : period_q + PcW'(1);
    pulse_d  = pulse_q;
    miss_d   = miss_q;

    unique case (state_q)
      StIdle: begin
        state_d = StRun;
      end
      StRun: begin
        if (tick) begin
          if (health_ok) begin
            state_d = StPulse;
            pulse_d = '0;
            miss_d  = '0;
          end else begin
            miss_d = miss_plus;
            if (miss_plus == MissLimit) begin
              state_d = StHalt;
            end
          end
        end
      end
      StPulse: begin
        if (pulse_q == PulseLast) begin
          state_d = StRun;
        end else begin
          pulse_d = pulse_q + PwW'(1);
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Disabling parks everything in IDLE with counters cleared.
    if (!enable) begin
      state_d  = StIdle;
      period_d = '0;
      pulse_d  = '0;
      miss_d   = '0;
    end

    heartbeat_d = (state_d == StPulse);
    halted_d    = (state_d == StHalt);
    force_d     = enable && kick_req && !kick_prev_q && (state_q != StIdle);
  end

  // State, counters and registered outputs; reset overrides every same-cycle event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      period_q    <= '0;
      pulse_q     <= '0;
      miss_q      <= '0;
      stale_cnt_q <= '{default: '0};
      stale_q     <= '0;
      heartbeat_q <= 1'b0;
      force_q     <= 1'b0;
      halted_q    <= 1'b0;
      kick_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      pulse_q     <= pulse_d;
      miss_q      <= miss_d;
      stale_cnt_q <= stale_cnt_d;
      stale_q     <= stale_d;
      heartbeat_q <= heartbeat_d;
      force_q     <= force_d;
      halted_q    <= halted_d;
      kick_prev_q <= kick_req;
    end
  end

  assign heartbeat   = heartbeat_q;
  assign force_reset = force_q;
  assign stale       = stale_q;
  assign halted      = halted_q;

`ifdef HB_STATS_EN
  logic [15:0] beat_count_q;
  logic [15:0] miss_total_q;
  logic        beat_inc;
  logic        miss_inc;

  assign beat_inc = enable && tick && health_ok;
  assign miss_inc = enable && tick && !health_ok;

  // Beat counter wraps; miss total saturates.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      beat_count_q <= 16'h0;
      miss_total_q <= 16'h0;
    end else begin
      if (beat_inc) begin
        beat_count_q <= beat_count_q + 16'h1;
      end
      if (miss_inc && (miss_total_q != 16'hFFFF)) begin
        miss_total_q <= miss_total_q + 16'h1;
      end
    end
  end

  assign beat_count = beat_count_q;
  assign miss_total = miss_total_q;
`else
  assign beat_count = 16'h0;
  assign miss_total = 16'h0;
`endif

endmodule
